// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall controller: merges per-stage stall requests and a multi-cycle
// EX sequencer into the stall vector, with a saturating stall statistic and watchdog.
//   state | meaning
//   IDLE  | no multi-cycle op in flight; a start with len>1 enters RUN
//   RUN   | op occupies EX; cnt counts down to the final (done) cycle
module pipe_stall_ctrl #(
    parameter int MCYC_W  = 6,
    parameter int STAT_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_if,
    input  logic              stallreq_id,
    input  logic              stallreq_ex,
    input  logic              stallreq_mem,
    input  logic              mcyc_start,
    input  logic [MCYC_W-1:0] mcyc_len,
    output logic              mcyc_busy,
    output logic              mcyc_done,
    output logic [5:0]        stall,
    input  logic              stat_clr,
    output logic [STAT_W-1:0] stall_cycles,
    output logic              stall_timeout
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic [MCYC_W-1:0] cnt_q, cnt_d;
    logic [CW-1:0]     consec_q;
    logic [STAT_W-1:0] stat_q;
    logic              to_q;
    logic              len_gt1;
    logic              ex_req;

    assign len_gt1   = mcyc_len > MCYC_W'(1);
    assign mcyc_busy = (state_q == RUN);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcyc_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (mcyc_start) begin
                    if (len_gt1) begin
                        cnt_d   = mcyc_len - MCYC_W'(1);
                        state_d = RUN;
                    end else begin
                        mcyc_done = 1'b1;
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_q - MCYC_W'(1);
                if (cnt_q == MCYC_W'(1)) begin
                    mcyc_done = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst) mcyc_done = 1'b0;
    end

    // The final RUN cycle releases EX, so the op holds the stall for len-1 cycles.
    assign ex_req = stallreq_ex
                  | (mcyc_busy && cnt_q != MCYC_W'(1))
                  | (state_q == IDLE && mcyc_start && len_gt1);

    always_comb begin
        stall = 6'b000000;
        if (rst)               stall = 6'b000000;
        else if (stallreq_mem) stall = 6'b011111;
        else if (ex_req)       stall = 6'b001111;
        else if (stallreq_id)  stall = 6'b000111;
        else if (stallreq_if)  stall = 6'b000011;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            consec_q <= '0;
            stat_q   <= '0;
            to_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (stat_clr) begin
                consec_q <= '0;
                stat_q   <= '0;
                to_q     <= 1'b0;
            end else begin
                if (stall[0]) begin
                    if (consec_q != CW'(TIMEOUT)) consec_q <= consec_q + CW'(1);
                    if (stat_q != '1)             stat_q   <= stat_q + STAT_W'(1);
                    if (consec_q >= CW'(TIMEOUT - 1)) to_q <= 1'b1;
                end else begin
                    consec_q <= '0;
                end
            end
        end
    end

    assign stall_cycles  = stat_q;
    assign stall_timeout = to_q;
endmodule
